// File: rtl/fp_pkg.sv
// Shared types and helpers for the FP compare/branch path: condition codes,
// the {UN,LT,GT,EQ} flags word, compare-unit result encodings and operand classifiers.
package fp_pkg;

  typedef enum logic [2:0] {
    COND_EQ     = 3'd0,
    COND_NE     = 3'd1,
    COND_LT     = 3'd2,
    COND_LE     = 3'd3,
    COND_GT     = 3'd4,
    COND_GE     = 3'd5,
    COND_UN     = 3'd6,
    COND_ALWAYS = 3'd7
  } cond_e;

  typedef struct packed {
    logic un;
    logic lt;
    logic gt;
    logic eq;
  } flags_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  localparam logic [1:0] CMP_EQ  = 2'b00;
  localparam logic [1:0] CMP_GT  = 2'b01;
  localparam logic [1:0] CMP_LT  = 2'b11;
  localparam logic [1:0] CMP_ILL = 2'b10;

  localparam flags_t FLAGS_UN = '{un: 1'b1, lt: 1'b0, gt: 1'b0, eq: 1'b0};
  localparam flags_t FLAGS_LT = '{un: 1'b0, lt: 1'b1, gt: 1'b0, eq: 1'b0};
  localparam flags_t FLAGS_GT = '{un: 1'b0, lt: 1'b0, gt: 1'b1, eq: 1'b0};
  localparam flags_t FLAGS_EQ = '{un: 1'b0, lt: 1'b0, gt: 1'b0, eq: 1'b1};

  function automatic logic is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  function automatic logic is_zero(input logic [31:0] x);
    return x[30:0] == 31'd0;
  endfunction

  // The illegal encoding is folded into unordered rather than trusted.
  function automatic flags_t result_to_flags(input logic [1:0] r);
    case (r)
      CMP_EQ:  return FLAGS_EQ;
      CMP_GT:  return FLAGS_GT;
      CMP_LT:  return FLAGS_LT;
      default: return FLAGS_UN;
    endcase
  endfunction

  function automatic logic eval_cond(input cond_e c, input flags_t f);
    case (c)
      COND_EQ:  return f.eq;
      COND_NE:  return !f.eq;
      COND_LT:  return f.lt;
      COND_LE:  return f.lt | f.eq;
      COND_GT:  return f.gt;
      COND_GE:  return f.gt | f.eq;
      COND_UN:  return f.un;
      default:  return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/fp_operand_classify.sv
// Combinational NaN / zero detect for one IEEE-754 single operand.
module fp_operand_classify
  import fp_pkg::*;
(
  input  logic [31:0] op_i,
  output logic        nan_o,
  output logic        zero_o
);

  assign nan_o  = is_nan(op_i);
  assign zero_o = is_zero(op_i);

endmodule

// File: rtl/float_cmp_branch_unit.sv
// Request/response sequencer around the FP compare unit: issues operands, waits out
// the compare latency, folds in NaN/zero special cases and evaluates the branch condition.
module float_cmp_branch_unit
  import fp_pkg::*;
#(
  parameter int CMP_LATENCY = 1,
  parameter int FLAG_W      = 4
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [31:0]       req_a_i,
  input  logic [31:0]       req_b_i,
  input  logic [2:0]        req_cond_i,
  output logic [31:0]       cmp_a_o,
  output logic [31:0]       cmp_b_o,
  output logic              cmp_enable_o,
  input  logic [1:0]        cmp_result_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic              rsp_taken_o,
  output logic [FLAG_W-1:0] rsp_flags_o,
  output logic [FLAG_W-1:0] flags_q_o
);

  localparam logic [2:0] CNT_INIT = 3'(CMP_LATENCY - 1);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] cmp_a_q, cmp_b_q;
  cond_e       cond_q;
  logic        any_nan_q, both_zero_q;
  flags_t      rsp_flags_q, rsp_flags_d, flags_q;
  logic        rsp_taken_q;
  logic        load_rsp;
  logic        a_nan, a_zero, b_nan, b_zero;
  logic        accept;
  logic        bypass;

  fp_operand_classify u_cls_a (.op_i(req_a_i), .nan_o(a_nan), .zero_o(a_zero));
  fp_operand_classify u_cls_b (.op_i(req_b_i), .nan_o(b_nan), .zero_o(b_zero));

  assign accept = (state_q == S_IDLE) && req_valid_i;
  assign bypass = any_nan_q | both_zero_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    load_rsp    = 1'b0;
    rsp_flags_d = rsp_flags_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid_i) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (bypass) begin
          // NaN wins over signed zero: any NaN operand is unordered.
          state_d     = S_RESP;
          load_rsp    = 1'b1;
          rsp_flags_d = any_nan_q ? FLAGS_UN : FLAGS_EQ;
        end else begin
          state_d = S_WAIT;
          cnt_d   = CNT_INIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == 3'd0) begin
          state_d     = S_RESP;
          load_rsp    = 1'b1;
          rsp_flags_d = result_to_flags(cmp_result_i);
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= 3'd0;
      cmp_a_q     <= 32'd0;
      cmp_b_q     <= 32'd0;
      cond_q      <= COND_EQ;
      any_nan_q   <= 1'b0;
      both_zero_q <= 1'b0;
      rsp_flags_q <= '0;
      rsp_taken_q <= 1'b0;
      flags_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        cmp_a_q     <= req_a_i;
        cmp_b_q     <= req_b_i;
        cond_q      <= cond_e'(req_cond_i);
        any_nan_q   <= a_nan | b_nan;
        both_zero_q <= a_zero & b_zero;
      end
      if (load_rsp) begin
        rsp_flags_q <= rsp_flags_d;
        flags_q     <= rsp_flags_d;
        rsp_taken_q <= eval_cond(cond_q, rsp_flags_d);
      end
    end
  end

  assign req_ready_o  = (state_q == S_IDLE);
  assign cmp_enable_o = (state_q == S_ISSUE) && !bypass;
  assign cmp_a_o      = cmp_a_q;
  assign cmp_b_o      = cmp_b_q;
  assign rsp_valid_o  = (state_q == S_RESP);
  assign rsp_taken_o  = rsp_taken_q;
  assign rsp_flags_o  = rsp_flags_q;
  assign flags_q_o    = flags_q;

endmodule
